// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S master receiver.
// Divides sys_clk down to bclk, generates ws, and deserialises one DATA_W-bit
// left and right sample per frame (MSB first). A complete pair is presented
// with a one-cycle receive_valid strobe.
// Optional feature: define I2S_LEFT_JUSTIFIED_EN for left-justified framing
// (no one-bit delay after the ws transition). Default build is standard I2S.
module i2s_receiver #(
  parameter int BCLK_DIV = 2,   // sys_clk cycles per bclk half-period (>=1)
  parameter int DATA_W   = 24,  // captured bits per channel
  parameter int SLOT_W   = 32   // bclk periods per channel slot (>= DATA_W+1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              sdata,
  output logic              ws,
  output logic              bclk,
  output logic              receive_valid,
  output logic [DATA_W-1:0] receive_left_data,
  output logic [DATA_W-1:0] receive_right_data
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);

`ifdef I2S_LEFT_JUSTIFIED_EN
  // Left-justified: MSB sits in the first bclk period of each slot.
  localparam int FIRST_OFS = 0;
`else
  // I2S: MSB is delayed by one bclk period after the ws transition.
  localparam int FIRST_OFS = 1;
`endif

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] LEFT_FIRST = BIT_W'(FIRST_OFS);
  localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_W + FIRST_OFS);
  localparam logic [BIT_W-1:0] RIGHT_LAST = BIT_W'(SLOT_W + FIRST_OFS + DATA_W - 1);
  localparam logic [BIT_W-1:0] DATA_LEN   = BIT_W'(DATA_W);

  // Divider and bit-clock state
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [DIV_W-1:0]  div_cnt_next;
  logic              bclk_reg;
  logic              tick;
  logic              rise_evt;
  logic              fall_evt;

  // Frame position state
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_next;
  logic              ws_reg;
  logic              ws_next;

  // Capture state
  logic [BIT_W-1:0]  left_idx;
  logic [BIT_W-1:0]  right_idx;
  logic              left_take;
  logic              right_take;
  logic              last_bit;
  logic [DATA_W-1:0] left_shift_reg;
  logic [DATA_W-1:0] right_shift_reg;
  logic              done_reg;

  // Output holding registers
  logic [DATA_W-1:0] left_out_reg;
  logic [DATA_W-1:0] right_out_reg;
  logic              valid_reg;

  // Divider wrap and the bclk edge events it produces.
  always_comb begin
    tick         = (div_cnt_reg == DIV_LAST);
    rise_evt     = tick & ~bclk_reg;
    fall_evt     = tick & bclk_reg;
    div_cnt_next = tick ? '0 : div_cnt_reg + DIV_W'(1);
  end

  // Frame position advance on each bclk falling event; ws follows position.
  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    if (fall_evt) begin
      bit_cnt_next = (bit_cnt_reg == FRAME_LAST) ? '0 : bit_cnt_reg + BIT_W'(1);
    end
    ws_next = (bit_cnt_next >= SLOT_START);
  end

  // Capture windows: offsets wrap modulo 2^BIT_W, so positions before the
  // window start land far above DATA_W and are rejected by one compare.
  always_comb begin
    left_idx   = bit_cnt_reg - LEFT_FIRST;
    right_idx  = bit_cnt_reg - RIGHT_FIRST;
    left_take  = rise_evt && (left_idx < DATA_LEN);
    right_take = rise_evt && (right_idx < DATA_LEN);
    last_bit   = rise_evt && (bit_cnt_reg == RIGHT_LAST);
  end

  // Divider counter and registered bit clock.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      if (tick) begin
        bclk_reg <= ~bclk_reg;
      end
    end
  end

  // Bit position within the frame and word select.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bit_cnt_reg <= '0;
      ws_reg      <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      ws_reg      <= ws_next;
    end
  end

  // Shift serial data in MSB first while inside each channel's data window.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      left_shift_reg  <= '0;
      right_shift_reg <= '0;
      done_reg        <= 1'b0;
    end else begin
      if (left_take) begin
        left_shift_reg <= {left_shift_reg[DATA_W-2:0], sdata};
      end
      if (right_take) begin
        right_shift_reg <= {right_shift_reg[DATA_W-2:0], sdata};
      end
      done_reg <= last_bit;
    end
  end

  // Load both channels together one cycle after the right LSB and strobe valid.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      left_out_reg  <= '0;
      right_out_reg <= '0;
      valid_reg     <= 1'b0;
    end else begin
      valid_reg <= done_reg;
      if (done_reg) begin
        left_out_reg  <= left_shift_reg;
        right_out_reg <= right_shift_reg;
      end
    end
  end

  assign bclk               = bclk_reg;
  assign ws                 = ws_reg;
  assign receive_valid      = valid_reg;
  assign receive_left_data  = left_out_reg;
  assign receive_right_data = right_out_reg;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: acts as the codec (drives sdata after each bclk fall) and
// scoreboards the left/right pairs. Edge index 0 is the last sys_clk edge
// that samples sys_rst high; rel holds the index of the most recent edge.
module tb_i2s_receiver;

  localparam int BCLK_DIV   = 2;
  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int FRAME_CYC  = FRAME_BITS * 2 * BCLK_DIV;

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int              OFS         = 0;
  localparam logic [DATA_W-1:0] ALT_EXP   = 24'h555555;
  localparam int              FIRST_VALID = 223;
`else
  localparam int              OFS         = 1;
  localparam logic [DATA_W-1:0] ALT_EXP   = 24'hAAAAAA;
  localparam int              FIRST_VALID = 227;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              sdata   = 1'b0;
  logic              ws;
  logic              bclk;
  logic              receive_valid;
  logic [DATA_W-1:0] receive_left_data;
  logic [DATA_W-1:0] receive_right_data;

  i2s_receiver #(.BCLK_DIV(BCLK_DIV), .DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .sdata             (sdata),
    .ws                (ws),
    .bclk              (bclk),
    .receive_valid     (receive_valid),
    .receive_left_data (receive_left_data),
    .receive_right_data(receive_right_data)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  pair_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    nvalid     = 0;

  // Edge index since reset release and whether the last edge was in reset.
  int   rel   = 0;
  logic rst_q = 1'b1;
  always @(posedge sys_clk) begin
    if (sys_rst) rel <= 0;
    else         rel <= rel + 1;
    rst_q <= sys_rst;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, rel, act, exp);
    end
  endtask

  // Codec state: bits[k] is driven during the bclk period following fall k.
  logic [FRAME_BITS-1:0] bits;
  int                    k;
  int                    fidx;
  logic                  prev_bclk;

  task automatic start_frame();
    logic [DATA_W-1:0] lw;
    logic [DATA_W-1:0] rw;
    pair_t p;
    if (fidx < 2) begin
      for (int i = 0; i < FRAME_BITS; i++) bits[i] = i[0];
      lw = ALT_EXP;
      rw = ALT_EXP;
    end else begin
      if (fidx == 2) begin
        lw   = 24'h7FFFFF;
        rw   = 24'h800000;
        bits = '1;
      end else begin
        lw = DATA_W'($urandom);
        rw = DATA_W'($urandom);
        for (int i = 0; i < FRAME_BITS; i++) bits[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < DATA_W; i++) begin
        bits[OFS + i]          = lw[DATA_W-1-i];
        bits[SLOT_W + OFS + i] = rw[DATA_W-1-i];
      end
    end
    p.l = lw;
    p.r = rw;
    exp_q.push_back(p);
    fidx++;
    $display("frame %0d issued: left=%h right=%h", fidx - 1, lw, rw);
  endtask

  task automatic codec_step();
    if (sys_rst) begin
      exp_q.delete();
      fidx      = 0;
      k         = 0;
      prev_bclk = 1'b0;
      start_frame();
    end else begin
      if (prev_bclk && !bclk) begin
        k++;
        if (k == FRAME_BITS) begin
          k = 0;
          start_frame();
        end
      end
      prev_bclk = bclk;
    end
    sdata = bits[k];
  endtask

  // Stimulus: initial reset, free run, long reset, 1-cycle reset at edge 100.
  initial begin
    int target;
    sys_rst = 1'b1;
    repeat (5) begin
      @(negedge sys_clk);
      codec_step();
    end
    sys_rst = 1'b0;
    for (int c = 0; c < 12 * FRAME_CYC && nvalid < 10; c++) begin
      @(negedge sys_clk);
      codec_step();
    end
    check("run1_valid_count", 64'(nvalid >= 10), 64'd1);

    sys_rst = 1'b1;
    repeat (5) begin
      @(negedge sys_clk);
      codec_step();
    end
    sys_rst = 1'b0;
    for (int c = 0; c < 200 && rel != 99; c++) begin
      @(negedge sys_clk);
      codec_step();
    end
    check("reach_edge_99", 64'(rel), 64'd99);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    codec_step();
    sys_rst = 1'b0;

    target = nvalid + 4;
    for (int c = 0; c < 6 * FRAME_CYC && nvalid < target; c++) begin
      @(negedge sys_clk);
      codec_step();
    end
    check("run2_valid_count", 64'(nvalid >= target), 64'd1);
    repeat (4) begin
      @(negedge sys_clk);
      codec_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Monitor: clocks against the divider rules, valid timing, scoreboard pops.
  initial begin
    bit    seen;
    bit    chk_low;
    int    last;
    int    e;
    logic  exp_b;
    logic  exp_ws;
    pair_t p;
    seen    = 1'b0;
    chk_low = 1'b0;
    last    = 0;
    forever begin
      @(negedge sys_clk);
      if (chk_low) begin
        check("valid_width", 64'(receive_valid), 64'd0);
        chk_low = 1'b0;
      end
      if (rst_q) begin
        check("reset_state",
              {14'd0, bclk, ws, receive_valid, receive_left_data, receive_right_data}, 64'd0);
        seen = 1'b0;
      end else begin
        e      = rel;
        exp_b  = (e >= BCLK_DIV) && ((((e - BCLK_DIV) / BCLK_DIV) % 2) == 0);
        exp_ws = (((e / (2 * BCLK_DIV)) % FRAME_BITS) >= SLOT_W);
        check("bclk", 64'(bclk), 64'(exp_b));
        check("ws", 64'(ws), 64'(exp_ws));
        if (receive_valid) begin
          nvalid++;
          chk_low = 1'b1;
          if (!seen) check("first_valid_edge", 64'(rel), 64'(FIRST_VALID));
          else       check("valid_period", 64'(rel - last), 64'(FRAME_CYC));
          seen = 1'b1;
          last = rel;
          if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
          end else begin
            p = exp_q.pop_front();
            $display("valid at edge %0d: left=%h right=%h (expect %h %h)",
                     rel, receive_left_data, receive_right_data, p.l, p.r);
            check("left_data", 64'(receive_left_data), 64'(p.l));
            check("right_data", 64'(receive_right_data), 64'(p.r));
          end
        end else if (!seen) begin
          check("data_before_first_valid",
                {16'd0, receive_left_data, receive_right_data}, 64'd0);
        end
      end
    end
  end

endmodule
